// File: rtl/chiplet_pkg.sv
// Shared chiplet-link definitions: command and length codes, header bit positions,
// the RX state type and the header decode helper used by both link FSMs.
package chiplet_pkg;

    localparam int FLIT_W = 40;
    localparam int WORD_W = 32;
    localparam int ID_W   = 6;

    localparam logic [2:0] CMD_RD_REQ = 3'b000;
    localparam logic [2:0] CMD_WR_REQ = 3'b001;
    localparam logic [2:0] CMD_RD_RSP = 3'b010;

    localparam logic [2:0] LEN_4B   = 3'd0;
    localparam logic [2:0] LEN_8B   = 3'd1;
    localparam logic [2:0] LEN_16B  = 3'd2;
    localparam logic [2:0] LEN_32B  = 3'd3;
    localparam logic [2:0] LEN_64B  = 3'd4;
    localparam logic [2:0] LEN_128B = 3'd5;

    localparam int HDR_MODE_BIT  = 0;
    localparam int HDR_VALID_BIT = 1;
    localparam int HDR_CMD_LSB   = 2;
    localparam int HDR_LEN_LSB   = 5;
    localparam int HDR_ADDR_LSB  = 8;
    localparam int HDR_TID_LSB   = 8;
    localparam int HDR_DID_LSB   = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic              ext;
        logic              vld;
        logic [2:0]        cmd;
        logic [2:0]        len;
        logic [WORD_W-1:0] addr;
        logic [ID_W-1:0]   tid;
        logic [ID_W-1:0]   did;
    } hdr_t;

    // Lightweight address and extended tid/did overlap; the caller picks by mode.
    function automatic hdr_t hdr_decode(input logic [FLIT_W-1:0] flit);
        hdr_t h;
        h.ext  = flit[HDR_MODE_BIT];
        h.vld  = flit[HDR_VALID_BIT];
        h.cmd  = flit[HDR_CMD_LSB +: 3];
        h.len  = flit[HDR_LEN_LSB +: 3];
        h.addr = flit[HDR_ADDR_LSB +: WORD_W];
        h.tid  = flit[HDR_TID_LSB +: ID_W];
        h.did  = flit[HDR_DID_LSB +: ID_W];
        return h;
    endfunction

    function automatic logic hdr_bad(input hdr_t h, input logic [2:0] max_len);
        return (h.cmd > CMD_RD_RSP) || (h.len > max_len);
    endfunction

    function automatic logic [5:0] word_count(input logic [2:0] len);
        return 6'd1 << len;
    endfunction

endpackage

// File: rtl/slave_rx_fsm.sv
// Receive-side depacketizer: parses header/address/data flits from the link RX FIFO
// into registered per-field value/valid pulses for the slave-side consumer.
module slave_rx_fsm
    import chiplet_pkg::*;
#(
    parameter int DATA_LINE_WIDTH = 40,
    parameter int WORD_SIZE       = 32,
    parameter int TID_WIDTH       = 6,
    parameter int DID_WIDTH       = 6,
    parameter int MAX_LEN_CODE    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_LINE_WIDTH-1:0] i_flit,
    input  logic                       i_flit_valid,
    output logic                       o_flit_ready,
    input  logic                       i_slave_rx_ready,
    output logic [2:0]                 o_slave_rx_cmd,
    output logic                       o_slave_rx_cmd_valid,
    output logic [2:0]                 o_slave_rx_length,
    output logic                       o_slave_rx_length_valid,
    output logic [WORD_SIZE-1:0]       o_slave_rx_addr,
    output logic                       o_slave_rx_addr_valid,
    output logic [TID_WIDTH-1:0]       o_slave_rx_tid,
    output logic                       o_slave_rx_tid_valid,
    output logic [DID_WIDTH-1:0]       o_slave_rx_did,
    output logic                       o_slave_rx_did_valid,
    output logic [WORD_SIZE-1:0]       o_slave_rx_data,
    output logic                       o_slave_rx_data_valid,
    output logic                       o_busy,
    output logic                       o_proto_err
);

    localparam logic [2:0] MAX_LEN = MAX_LEN_CODE[2:0];

    rx_state_t            state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [2:0]           len_q, len_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [TID_WIDTH-1:0] tid_q, tid_d;
    logic [DID_WIDTH-1:0] did_q, did_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic cmd_v_q, cmd_v_d, len_v_q, len_v_d, addr_v_q, addr_v_d;
    logic tid_v_q, tid_v_d, did_v_q, did_v_d, data_v_q, data_v_d;
    logic err_q, err_d;

    hdr_t hdr;
    logic consume;

    assign o_flit_ready = i_slave_rx_ready;
    assign consume      = i_flit_valid && i_slave_rx_ready;
    assign hdr          = hdr_decode(i_flit);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        addr_d   = addr_q;
        tid_d    = tid_q;
        did_d    = did_q;
        data_d   = data_q;
        cmd_v_d  = 1'b0;
        len_v_d  = 1'b0;
        addr_v_d = 1'b0;
        tid_v_d  = 1'b0;
        did_v_d  = 1'b0;
        data_v_d = 1'b0;
        err_d    = 1'b0;

        if (consume) begin
            unique case (state_q)
                IDLE: begin
                    if (hdr.vld) begin
                        if (hdr_bad(hdr, MAX_LEN)) begin
                            err_d = 1'b1;
                        end else begin
                            cmd_d   = hdr.cmd;
                            len_d   = hdr.len;
                            cmd_v_d = 1'b1;
                            len_v_d = 1'b1;
                            // Loaded here so both the direct and the via-ADDR path see it.
                            cnt_d   = word_count(hdr.len);
                            if (hdr.ext) begin
                                tid_d   = TID_WIDTH'(hdr.tid);
                                did_d   = DID_WIDTH'(hdr.did);
                                tid_v_d = 1'b1;
                                did_v_d = 1'b1;
                                state_d = (hdr.cmd == CMD_RD_RSP) ? DATA : ADDR;
                            end else begin
                                if (hdr.cmd != CMD_RD_RSP) begin
                                    addr_d   = WORD_SIZE'(hdr.addr);
                                    addr_v_d = 1'b1;
                                end
                                state_d = (hdr.cmd == CMD_RD_REQ) ? IDLE : DATA;
                            end
                        end
                    end
                end
                ADDR: begin
                    addr_d   = i_flit[WORD_SIZE-1:0];
                    addr_v_d = 1'b1;
                    state_d  = (cmd_q == CMD_WR_REQ) ? DATA : IDLE;
                end
                DATA: begin
                    data_d   = i_flit[WORD_SIZE-1:0];
                    data_v_d = 1'b1;
                    cnt_d    = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            tid_q    <= '0;
            did_q    <= '0;
            data_q   <= '0;
            cmd_v_q  <= 1'b0;
            len_v_q  <= 1'b0;
            addr_v_q <= 1'b0;
            tid_v_q  <= 1'b0;
            did_v_q  <= 1'b0;
            data_v_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            tid_q    <= tid_d;
            did_q    <= did_d;
            data_q   <= data_d;
            cmd_v_q  <= cmd_v_d;
            len_v_q  <= len_v_d;
            addr_v_q <= addr_v_d;
            tid_v_q  <= tid_v_d;
            did_v_q  <= did_v_d;
            data_v_q <= data_v_d;
            err_q    <= err_d;
        end
    end

    assign o_slave_rx_cmd          = cmd_q;
    assign o_slave_rx_cmd_valid    = cmd_v_q;
    assign o_slave_rx_length       = len_q;
    assign o_slave_rx_length_valid = len_v_q;
    assign o_slave_rx_addr         = addr_q;
    assign o_slave_rx_addr_valid   = addr_v_q;
    assign o_slave_rx_tid          = tid_q;
    assign o_slave_rx_tid_valid    = tid_v_q;
    assign o_slave_rx_did          = did_q;
    assign o_slave_rx_did_valid    = did_v_q;
    assign o_slave_rx_data         = data_q;
    assign o_slave_rx_data_valid   = data_v_q;
    assign o_busy                  = (state_q != IDLE);
    assign o_proto_err             = err_q;

endmodule

// File: tb/tb_slave_rx_fsm.sv
// Bench for slave_rx_fsm: packets are built at packet level together with the
// output pulses each flit should produce, then driven with optional backpressure.
module tb_slave_rx_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] i_flit;
    logic        i_flit_valid;
    logic        o_flit_ready;
    logic        i_slave_rx_ready;
    logic [2:0]  o_cmd, o_len;
    logic [31:0] o_addr, o_data;
    logic [5:0]  o_tid, o_did;
    logic        o_cmd_v, o_len_v, o_addr_v, o_tid_v, o_did_v, o_data_v;
    logic        o_busy, o_proto_err;

    always #5 clk = ~clk;

    slave_rx_fsm dut (
        .clk                     (clk),
        .rst                     (rst),
        .i_flit                  (i_flit),
        .i_flit_valid            (i_flit_valid),
        .o_flit_ready            (o_flit_ready),
        .i_slave_rx_ready        (i_slave_rx_ready),
        .o_slave_rx_cmd          (o_cmd),
        .o_slave_rx_cmd_valid    (o_cmd_v),
        .o_slave_rx_length       (o_len),
        .o_slave_rx_length_valid (o_len_v),
        .o_slave_rx_addr         (o_addr),
        .o_slave_rx_addr_valid   (o_addr_v),
        .o_slave_rx_tid          (o_tid),
        .o_slave_rx_tid_valid    (o_tid_v),
        .o_slave_rx_did          (o_did),
        .o_slave_rx_did_valid    (o_did_v),
        .o_slave_rx_data         (o_data),
        .o_slave_rx_data_valid   (o_data_v),
        .o_busy                  (o_busy),
        .o_proto_err             (o_proto_err)
    );

    typedef struct {
        bit        cmd_v, len_v, addr_v, tid_v, did_v, data_v, err, busy;
        bit [2:0]  cmd, len;
        bit [31:0] addr, data;
        bit [5:0]  tid, did;
    } ev_t;

    logic [39:0] flit_q[$];
    ev_t         exp_q[$];
    logic [31:0] data_src[$];
    bit          stall_q[$];
    bit          busy_exp = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t ev_blank(input bit busy);
        ev_t e;
        e = '{default: '0};
        e.busy = busy;
        return e;
    endfunction

    task automatic check_event(input ev_t e);
        chk("cmd_valid",  o_cmd_v,     e.cmd_v);
        chk("len_valid",  o_len_v,     e.len_v);
        chk("addr_valid", o_addr_v,    e.addr_v);
        chk("tid_valid",  o_tid_v,     e.tid_v);
        chk("did_valid",  o_did_v,     e.did_v);
        chk("data_valid", o_data_v,    e.data_v);
        chk("proto_err",  o_proto_err, e.err);
        chk("busy",       o_busy,      e.busy);
        if (e.cmd_v)  chk("cmd",  o_cmd,  e.cmd);
        if (e.len_v)  chk("len",  o_len,  e.len);
        if (e.addr_v) chk("addr", o_addr, e.addr);
        if (e.tid_v)  chk("tid",  o_tid,  e.tid);
        if (e.did_v)  chk("did",  o_did,  e.did);
        if (e.data_v) chk("data", o_data, e.data);
        $display("t=%0t flit consumed: valids c%0b l%0b a%0b t%0b d%0b D%0b err%0b busy%0b",
                 $time, o_cmd_v, o_len_v, o_addr_v, o_tid_v, o_did_v, o_data_v, o_proto_err, o_busy);
    endtask

    task automatic check_reset_state(input string tag);
        ev_t e;
        e = ev_blank(1'b0);
        check_event(e);
        chk({tag, "_cmd"},  o_cmd,  3'd0);
        chk({tag, "_len"},  o_len,  3'd0);
        chk({tag, "_addr"}, o_addr, 32'd0);
        chk({tag, "_tid"},  o_tid,  6'd0);
        chk({tag, "_did"},  o_did,  6'd0);
        chk({tag, "_data"}, o_data, 32'd0);
    endtask

    // One packet: header, optional address flit, then 1<<len data words.
    task automatic add_pkt(input bit ext, input bit [2:0] cmd, input bit [2:0] len,
                           input bit [31:0] addr, input bit [5:0] tid, input bit [5:0] did,
                           input bit junk);
        ev_t e;
        bit  has_addr, has_data;
        int  n;
        logic [31:0] w;
        logic [7:0]  hi;
        has_addr = ext && (cmd != 3'd2);
        has_data = (cmd != 3'd0);
        e = ev_blank(has_addr || has_data);
        e.cmd_v = 1'b1; e.len_v = 1'b1; e.cmd = cmd; e.len = len;
        if (ext) begin
            flit_q.push_back({junk ? 20'($urandom) : 20'h0, did, tid, len, cmd, 2'b11});
            e.tid_v = 1'b1; e.did_v = 1'b1; e.tid = tid; e.did = did;
        end else begin
            flit_q.push_back({addr, len, cmd, 2'b10});
            if (cmd != 3'd2) begin
                e.addr_v = 1'b1; e.addr = addr;
            end
        end
        exp_q.push_back(e);
        if (has_addr) begin
            hi = junk ? 8'($urandom) : 8'h0;
            flit_q.push_back({hi, addr});
            e = ev_blank(has_data);
            e.addr_v = 1'b1; e.addr = addr;
            exp_q.push_back(e);
        end
        if (has_data) begin
            n = 1 << len;
            for (int i = 0; i < n; i++) begin
                w  = (data_src.size() > 0) ? data_src.pop_front() : $urandom;
                hi = junk ? 8'($urandom) : 8'h0;
                flit_q.push_back({hi, w});
                e = ev_blank(i != n - 1);
                e.data_v = 1'b1; e.data = w;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic add_raw(input logic [39:0] f, input bit err);
        ev_t e;
        e = ev_blank(1'b0);
        e.err = err;
        flit_q.push_back(f);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rnd, input int max_cons);
        int  cons = 0;
        int  cyc  = 0;
        bit  rdy, vld;
        ev_t e;
        while (flit_q.size() > 0 && cons < max_cons) begin
            if (cyc > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout: observed %0d flits left, required 0", flit_q.size());
                break;
            end
            cyc++;
            @(negedge clk);
            rdy = rnd ? ($urandom_range(0, 3) != 0) : ((stall_q.size() > 0) ? stall_q.pop_front() : 1'b1);
            vld = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            i_flit           = vld ? flit_q[0] : {8'($urandom), 32'($urandom)};
            i_flit_valid     = vld;
            i_slave_rx_ready = rdy;
            #1 chk("flit_ready", o_flit_ready, rdy);
            @(posedge clk);
            #1;
            if (vld && rdy) begin
                e = exp_q.pop_front();
                void'(flit_q.pop_front());
                cons++;
                check_event(e);
                busy_exp = e.busy;
            end else begin
                e = ev_blank(busy_exp);
                check_event(e);
            end
        end
        @(negedge clk);
        i_flit_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_flit_valid = 1'b0;
        i_slave_rx_ready = 1'b1;
        @(posedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;
        flit_q.delete();
        exp_q.delete();
        busy_exp = 1'b0;
    endtask

    initial begin
        bit [2:0] c, l;
        int       r;
        rst = 1'b1;
        i_flit = '0;
        i_flit_valid = 1'b0;
        i_slave_rx_ready = 1'b1;
        do_reset();

        // Lightweight write 8B: 0xFFDD000026, 0xAA, 0xBB
        data_src = '{32'hAA, 32'hBB};
        add_pkt(1'b0, 3'd1, 3'd1, 32'hFFDD0000, 6'd0, 6'd0, 1'b0);
        drive(1'b0, 1000);

        // Extended write 16B with ready low for 3 cycles after the second data word
        data_src = '{32'h1234, 32'h5678, 32'h2444, 32'h3666};
        add_pkt(1'b1, 3'd1, 3'd2, 32'h888, 6'h01, 6'h3F, 1'b0);
        stall_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(1'b0, 1000);

        // Extended read request then lightweight read response, back to back
        add_pkt(1'b1, 3'd0, 3'd2, 32'hAAA, 6'd2, 6'd7, 1'b0);
        data_src = '{32'hAA, 32'hBB};
        add_pkt(1'b0, 3'd2, 3'd1, 32'h0, 6'd0, 6'd0, 1'b0);
        drive(1'b0, 1000);

        // Bad header, then a normal header, then a zero flit in IDLE
        add_raw(40'h000000001E, 1'b1);
        add_pkt(1'b0, 3'd1, 3'd1, 32'hFFDD0000, 6'd0, 6'd0, 1'b0);
        add_raw(40'h0, 1'b0);
        drive(1'b0, 1000);

        // Reset after header plus one data word of a 16B write
        add_pkt(1'b0, 3'd1, 3'd2, 32'h12345678, 6'd0, 6'd0, 1'b0);
        drive(1'b0, 2);
        do_reset();
        add_pkt(1'b0, 3'd1, 3'd0, 32'hCAFE0000, 6'd0, 6'd0, 1'b0);
        drive(1'b0, 1000);

        // Randomized packet mix with random valid/ready
        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                add_raw({8'($urandom), 30'($urandom), 1'b0, 1'($urandom)}, 1'b0);
            end else if (r == 1) begin
                c = 3'($urandom_range(0, 7));
                l = 3'($urandom_range(0, 7));
                if (c <= 3'd2 && l <= 3'd5) c = 3'($urandom_range(3, 7));
                add_raw({32'($urandom), l, c, 1'b1, 1'($urandom)}, 1'b1);
            end else begin
                c = 3'($urandom_range(0, 2));
                l = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 3));
                add_pkt(1'($urandom), c, l, $urandom, 6'($urandom), 6'($urandom), 1'b1);
            end
        end
        drive(1'b1, 100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_rx_fsm.md
Name: slave_rx_fsm

Overview:
- Receive-side depacketizer for the chiplet link. It is the far-end counterpart of the master TX FSM.
- Consumes 40-bit flits from the link RX FIFO and parses lightweight and extended packets: write request, read request and read response.
- Drives per-field value/valid outputs (cmd, length, addr, tid, did, data) to the slave-side consumer, with backpressure through a single ready.

Parameters:
- DATA_LINE_WIDTH, 40, flit width.
- WORD_SIZE, 32, data/address word width.
- TID_WIDTH, 6, transaction ID width.
- DID_WIDTH, 6, destination ID width.
- MAX_LEN_CODE, 5, largest legal length code (128B).

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_flit  in  DATA_LINE_WIDTH  flit from link RX FIFO
- i_flit_valid  in  1  flit present
- o_flit_ready  out  1  flit consumed when i_flit_valid && o_flit_ready
- i_slave_rx_ready  in  1  downstream consumer ready
- o_slave_rx_cmd / o_slave_rx_cmd_valid  out  3 / 1  command
- o_slave_rx_length / o_slave_rx_length_valid  out  3 / 1  length code
- o_slave_rx_addr / o_slave_rx_addr_valid  out  WORD_SIZE / 1  address
- o_slave_rx_tid / o_slave_rx_tid_valid  out  TID_WIDTH / 1  transaction ID
- o_slave_rx_did / o_slave_rx_did_valid  out  DID_WIDTH / 1  destination ID
- o_slave_rx_data / o_slave_rx_data_valid  out  WORD_SIZE / 1  data word
- o_busy  out  1  packet in progress (state != IDLE)
- o_proto_err  out  1  one-cycle pulse on malformed header

Behaviour:
- Header flit fields:
  - [0] mode: 0 = lightweight, 1 = extended.
  - [1] valid.
  - [4:2] cmd: 000 = read request, 001 = write request, 010 = read response.
  - [7:5] length code.
  - Lightweight: [39:8] = address.
  - Extended: [13:8] = tid, [19:14] = did, [39:20] reserved and ignored.
- Address flit (extended only): [31:0]. Data flit: [31:0]. Bits [39:32] are ignored in both.
- Word count = 1 << length (1 to 32). Held in a 6-bit down-counter.
- o_flit_ready = i_slave_rx_ready, combinational.
- Stall: while ready is low, no flit is consumed, state and counter hold, and all *_valid outputs are 0.
- All outputs are registered. Latency is 1 cycle from flit consumption to the corresponding valid.
- Every *_valid is a one-cycle pulse per consumed flit. Value outputs hold their last value between pulses.
- Reset: state = IDLE, counter = 0, every *_valid = 0, o_proto_err = 0, o_busy = 0, all value outputs = 0. Reset mid-packet abandons the packet; no further pulses for it.
- State IDLE (consumed flit is interpreted as a header):
  - valid bit = 0: discard silently, stay in IDLE.
  - cmd in {011..111}, or length > MAX_LEN_CODE: pulse o_proto_err, discard, stay in IDLE.
  - Otherwise pulse cmd_valid and length_valid.
  - Extended header: also pulse tid_valid and did_valid.
  - Lightweight header, cmd != 010: also pulse addr_valid with [39:8].
- Next state after a good header:
  - Lightweight write request -> DATA.
  - Lightweight read request -> IDLE.
  - Extended write or read request -> ADDR.
  - Read response (either mode) -> DATA. No address is emitted for read responses.
- State ADDR: consumed flit pulses addr_valid.
  - Write request -> DATA, counter loaded with the word count.
  - Read request -> IDLE.
- State DATA: each consumed flit pulses data_valid and decrements the counter. When the counter reaches 0 (last word) -> IDLE.
- Back-to-back packets: a header may be consumed the cycle after the last data/addr flit, with no idle gap required.
- In ADDR and DATA, bit [1] is not interpreted; the flit is raw payload.
- Counter never wraps. The 32-word packet loads 32, which fits in 6 bits.

Decomposition:
- Shared package chiplet_pkg holds:
  - cmd constants CMD_RD_REQ, CMD_WR_REQ, CMD_RD_RSP;
  - length codes LEN_4B..LEN_128B;
  - header bit-position localparams;
  - enum rx_state_t {IDLE, ADDR, DATA}.
- These definitions are reused by the master TX FSM.
- No sub-module; header decode is a function in the package.

Test Plan:
- Lightweight write 8B: flits 0xFFDD000026, 0xAA, 0xBB, ready = 1 -> T+1: cmd = 1, len = 1, addr = 0xFFDD0000; T+2: data = 0xAA; T+3: data = 0xBB; then IDLE.
- Extended write 16B: 0x00000FC147, 0x888, 0x1234, 0x5678, 0x2444, 0x3666 -> cmd = 1, len = 2, tid = 0x01, did = 0x3F; then addr = 0x888; then four data pulses in order.
- Extended read request 0x000001C243, 0xAAA, then lightweight read response 0x000000002A, 0xAA, 0xBB back-to-back -> tid = 2, did = 7, addr = 0xAAA, no data for the request; response gives cmd = 2, len = 1, no addr, data 0xAA then 0xBB.
- Backpressure: during the extended write, drop i_slave_rx_ready for 3 cycles after the second data word -> o_flit_ready = 0, no valids, state holds; the remaining words arrive intact and none are duplicated.
- Bad header 0x000000001E (cmd = 7) -> o_proto_err pulses once, no field valids; the next flit 0xFFDD000026 parses as a normal header. A zero flit in IDLE produces no outputs.
- Assert rst after the header plus one data word of a 16B write -> all valids 0 and o_busy = 0 next cycle; the following flit is treated as a header.
